framebuffer_fetch: RTL and testbench
====================================

Name: framebuffer_fetch

Overview:
- Pixel-data source for the matrix scan stage.
- Turns the scan stage's column_address, row_address, brightness_mask and clk_pixel_load_en into per-pixel RGB bits for the top and bottom panel halves.
- Reads RGB565 words from a double-buffered framebuffer RAM through two read ports, expands each channel to 6 bits and selects the bit named by the brightness mask.
- Owns front/back buffer selection and swaps buffers only at frame boundaries.

Parameters:
PIXEL_WIDTH, 64, columns per row; column address width = $clog2(PIXEL_WIDTH)
PIXEL_HEIGHT, 32, panel rows; each half has PIXEL_HEIGHT/2 rows; row address width ROW_W = $clog2(PIXEL_HEIGHT/2)
RAM_LATENCY, 1, framebuffer read latency in cycles, legal values 1 or 2

Ports:
clk_in  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high
column_address  input  $clog2(PIXEL_WIDTH)  column being loaded
row_address  input  ROW_W  row being loaded
brightness_mask  input  6  one-hot bit-plane select, MSB first
pixel_load_en  input  1  high for each pixel-load cycle (64 per line)
swap_req  input  1  one-cycle pulse: writer has finished the back buffer
ram_rd_en  output  1  read strobe for both RAM ports
ram_addr_top  output  $clog2(PIXEL_WIDTH*PIXEL_HEIGHT)+1  {front_buffer, 1'b0, row, column}
ram_addr_bot  output  $clog2(PIXEL_WIDTH*PIXEL_HEIGHT)+1  {front_buffer, 1'b1, row, column}
ram_data_top  input  16  RGB565 word for ram_addr_top
ram_data_bot  input  16  RGB565 word for ram_addr_bot
rgb_top  output  3  {R,G,B} bits for the top half
rgb_bot  output  3  {R,G,B} bits for the bottom half
rgb_valid  output  1  rgb_top/rgb_bot hold a fetched pixel
front_buffer  output  1  buffer currently displayed
swap_ack  output  1  one-cycle pulse when a swap takes effect

Behaviour:
- Reset values, on the posedge following reset high: every output 0 (ram_rd_en, addresses, rgb_*, rgb_valid, front_buffer, swap_ack); swap pending flag 0; boundary flag 0; all pipeline valid bits cleared.
- Reset mid-line: in-flight data discarded; rgb_valid low the cycle after reset.

Pipeline:
- S0, cycle pixel_load_en sampled high: register ram_addr_top/ram_addr_bot from inputs and front_buffer; ram_rd_en=1 for exactly that cycle; capture brightness_mask and a valid bit into the delay line. When pixel_load_en is low, ram_rd_en=0 and the addresses hold.
- S1: RAM data available RAM_LATENCY cycles after S0; mask and valid are delayed by the same amount.
- S2, output register:
  - Channel expansion: R6={R5,R5[4]}, G6=G6, B6={B5,B5[4]}.
  - Bit select per channel = |(chan6 & mask); mask=0 gives 0.
  - rgb_valid = delayed valid.
  - rgb_* hold their last value when rgb_valid is low.
- Latency from the pixel_load_en sample edge to the rgb_valid edge: 2+RAM_LATENCY cycles, 3 at default.
- One pixel per cycle sustained; back-to-back load cycles produce back-to-back valid outputs with no bubbles.

Buffer swap:
- swap_req sets pending. swap_req while already pending is absorbed (still one pending).
- Frame boundary is detected on any cycle where row_address==0 and the registered previous row_address==PIXEL_HEIGHT/2-1; this sets the boundary flag.
- Swap executes on the first cycle with boundary flag=1, pending=1 and pixel_load_en=0. Effects: front_buffer toggles, pending clears, boundary flag clears, swap_ack=1 for one cycle.
- Boundary flag with pending=0: flag clears on the next pixel_load_en=0 cycle with no swap.
- swap_req in the same cycle a swap executes becomes a new pending request for the next frame.
- front_buffer never changes while pixel_load_en=1, so no line mixes buffers.

Optional Feature:
- Macro: FRAMEBUFFER_GAMMA_EN.
- Defined:
  - Each 6-bit channel passes through a registered gamma stage between S1 and S2: out = (in*in + 31) / 63, integer arithmetic, 12-bit intermediate.
  - Values: 0->0, 63->63, 32->16.
  - Latency becomes 3+RAM_LATENCY; mask and valid are delayed one extra cycle to match.
- Undefined: no gamma stage; latency 2+RAM_LATENCY.

Test Plan:
- Reset release, then 64 load cycles with mask=6'b100000; RAM top word 16'hF800, bottom 16'h001F -> rgb_top=3'b100, rgb_bot=3'b001; rgb_valid high for 64 consecutive cycles, starting 3 cycles after the first load edge.
- Top word 16'h07E0, mask stepped 100000..000001 across six lines -> G bit 1 on all six planes; R and B 0.
- Top word 16'h0400 (G6=6'b100000) -> G bit 1 only for mask 100000.
- swap_req pulsed mid-frame at row 5 -> front_buffer toggles only after row_address wraps 15->0, on the first pixel_load_en=0 cycle; swap_ack one cycle; subsequent ram_addr_top MSB=1; a second swap_req before the wrap causes no extra toggle.
- reset asserted during a load burst -> rgb_valid 0 and ram_rd_en 0 the next cycle; front_buffer 0; pending request lost.
- RAM_LATENCY=2, and FRAMEBUFFER_GAMMA_EN defined with G6=32 and mask=010000 -> latency 4 (5 with gamma); G bit 1 (gamma output 16).

Source files
------------

// File: rtl/framebuffer_fetch.sv
// Framebuffer pixel fetch for the matrix scan: RGB565 reads, 6-bit expansion, bit-plane select, front/back swap.
// Define FRAMEBUFFER_GAMMA_EN to insert a registered gamma stage (adds one cycle of latency).
module framebuffer_fetch #(
    parameter int PIXEL_WIDTH  = 64,
    parameter int PIXEL_HEIGHT = 32,
    parameter int RAM_LATENCY  = 1
) (
    input  logic                                      clk_in,
    input  logic                                      reset,
    input  logic [$clog2(PIXEL_WIDTH)-1:0]            column_address,
    input  logic [$clog2(PIXEL_HEIGHT/2)-1:0]         row_address,
    input  logic [5:0]                                brightness_mask,
    input  logic                                      pixel_load_en,
    input  logic                                      swap_req,
    output logic                                      ram_rd_en,
    output logic [$clog2(PIXEL_WIDTH*PIXEL_HEIGHT):0] ram_addr_top,
    output logic [$clog2(PIXEL_WIDTH*PIXEL_HEIGHT):0] ram_addr_bot,
    input  logic [15:0]                               ram_data_top,
    input  logic [15:0]                               ram_data_bot,
    output logic [2:0]                                rgb_top,
    output logic [2:0]                                rgb_bot,
    output logic                                      rgb_valid,
    output logic                                      front_buffer,
    output logic                                      swap_ack
);
    localparam int ROW_W  = $clog2(PIXEL_HEIGHT/2);
    localparam int ADDR_W = $clog2(PIXEL_WIDTH*PIXEL_HEIGHT) + 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(PIXEL_HEIGHT/2 - 1);

    // RGB565 -> {R6,G6,B6}; 5-bit channels replicate their MSB into the new LSB
    function automatic logic [17:0] expand(input logic [15:0] w);
        return {w[15:11], w[15], w[10:5], w[4:0], w[4]};
    endfunction

    logic              rd_en_reg;
    logic [ADDR_W-1:0] addr_top_reg, addr_bot_reg;
    logic [5:0]        mask_dly_reg [RAM_LATENCY+1];
    logic              valid_dly_reg [RAM_LATENCY+1];
    logic [5:0]        s1_top_reg [3];
    logic [5:0]        s1_bot_reg [3];
    logic [5:0]        s1_mask_reg;
    logic              s1_valid_reg;
    logic [5:0]        pre_top [3];
    logic [5:0]        pre_bot [3];
    logic [5:0]        pre_mask;
    logic              pre_valid;
    logic [2:0]        sel_top, sel_bot;
    logic [2:0]        rgb_top_reg, rgb_bot_reg;
    logic              rgb_valid_reg;
    logic              front_reg, pending_reg, boundary_reg, ack_reg;
    logic [ROW_W-1:0]  prev_row_reg;
    logic              swap_now;
    logic [17:0]       exp_top, exp_bot;

    // S0: address register and head of the mask/valid delay line
    always_ff @(posedge clk_in) begin
        if (reset) begin
            rd_en_reg        <= 1'b0;
            addr_top_reg     <= '0;
            addr_bot_reg     <= '0;
            mask_dly_reg[0]  <= '0;
            valid_dly_reg[0] <= 1'b0;
        end else begin
            rd_en_reg        <= pixel_load_en;
            valid_dly_reg[0] <= pixel_load_en;
            mask_dly_reg[0]  <= brightness_mask;
            if (pixel_load_en) begin
                addr_top_reg <= {front_reg, 1'b0, row_address, column_address};
                addr_bot_reg <= {front_reg, 1'b1, row_address, column_address};
            end
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi <= RAM_LATENCY; gi++) begin : g_dly
            always_ff @(posedge clk_in) begin
                if (reset) begin
                    mask_dly_reg[gi]  <= '0;
                    valid_dly_reg[gi] <= 1'b0;
                end else begin
                    mask_dly_reg[gi]  <= mask_dly_reg[gi-1];
                    valid_dly_reg[gi] <= valid_dly_reg[gi-1];
                end
            end
        end
    endgenerate

    assign exp_top = expand(ram_data_top);
    assign exp_bot = expand(ram_data_bot);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            s1_mask_reg  <= '0;
            s1_valid_reg <= 1'b0;
        end else begin
            s1_mask_reg  <= mask_dly_reg[RAM_LATENCY];
            s1_valid_reg <= valid_dly_reg[RAM_LATENCY];
        end
    end

`ifdef FRAMEBUFFER_GAMMA_EN
    function automatic logic [5:0] gamma(input logic [5:0] c);
        logic [11:0] sq;
        sq = 12'(c) * 12'(c) + 12'd31;
        return 6'(sq / 12'd63);
    endfunction

    logic [5:0] gam_top_reg [3];
    logic [5:0] gam_bot_reg [3];
    logic [5:0] gam_mask_reg;
    logic       gam_valid_reg;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            gam_mask_reg  <= '0;
            gam_valid_reg <= 1'b0;
        end else begin
            gam_mask_reg  <= s1_mask_reg;
            gam_valid_reg <= s1_valid_reg;
        end
    end
    assign pre_mask  = gam_mask_reg;
    assign pre_valid = gam_valid_reg;
`else
    assign pre_mask  = s1_mask_reg;
    assign pre_valid = s1_valid_reg;
`endif

    // Index 2 = R, 1 = G, 0 = B throughout
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            always_ff @(posedge clk_in) begin
                if (reset) begin
                    s1_top_reg[gi] <= '0;
                    s1_bot_reg[gi] <= '0;
                end else begin
                    s1_top_reg[gi] <= exp_top[gi*6 +: 6];
                    s1_bot_reg[gi] <= exp_bot[gi*6 +: 6];
                end
            end
`ifdef FRAMEBUFFER_GAMMA_EN
            always_ff @(posedge clk_in) begin
                if (reset) begin
                    gam_top_reg[gi] <= '0;
                    gam_bot_reg[gi] <= '0;
                end else begin
                    gam_top_reg[gi] <= gamma(s1_top_reg[gi]);
                    gam_bot_reg[gi] <= gamma(s1_bot_reg[gi]);
                end
            end
            assign pre_top[gi] = gam_top_reg[gi];
            assign pre_bot[gi] = gam_bot_reg[gi];
`else
            assign pre_top[gi] = s1_top_reg[gi];
            assign pre_bot[gi] = s1_bot_reg[gi];
`endif
            assign sel_top[gi] = |(pre_top[gi] & pre_mask);
            assign sel_bot[gi] = |(pre_bot[gi] & pre_mask);
        end
    endgenerate

    // S2: output register, holds the last pixel while no new one arrives
    always_ff @(posedge clk_in) begin
        if (reset) begin
            rgb_valid_reg <= 1'b0;
            rgb_top_reg   <= '0;
            rgb_bot_reg   <= '0;
        end else begin
            rgb_valid_reg <= pre_valid;
            if (pre_valid) begin
                rgb_top_reg <= sel_top;
                rgb_bot_reg <= sel_bot;
            end
        end
    end

    // Swaps only in a load gap so a displayed line never mixes buffers
    assign swap_now = boundary_reg && pending_reg && !pixel_load_en;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            front_reg    <= 1'b0;
            pending_reg  <= 1'b0;
            boundary_reg <= 1'b0;
            ack_reg      <= 1'b0;
            prev_row_reg <= '0;
        end else begin
            prev_row_reg <= row_address;
            ack_reg      <= swap_now;
            pending_reg  <= swap_now ? swap_req : (pending_reg | swap_req);
            if (swap_now)
                front_reg <= ~front_reg;
            if (row_address == '0 && prev_row_reg == LAST_ROW)
                boundary_reg <= 1'b1;
            else if (!pixel_load_en)
                boundary_reg <= 1'b0;
        end
    end

    assign ram_rd_en    = rd_en_reg;
    assign ram_addr_top = addr_top_reg;
    assign ram_addr_bot = addr_bot_reg;
    assign rgb_top      = rgb_top_reg;
    assign rgb_bot      = rgb_bot_reg;
    assign rgb_valid    = rgb_valid_reg;
    assign front_buffer = front_reg;
    assign swap_ack     = ack_reg;
endmodule

// File: tb/tb_framebuffer_fetch.sv
// Bench for framebuffer_fetch: two instances (RAM_LATENCY 1 and 2) against a cycle-level reference model.
module tb_framebuffer_fetch;
`ifdef FRAMEBUFFER_GAMMA_EN
    localparam int GX = 1;
`else
    localparam int GX = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1, load = 1'b0, swap_req = 1'b0;
    logic [5:0]  col = '0, mask = '0;
    logic [3:0]  row = '0;

    logic        rd1, v1, fb1, ack1, rd2, v2, fb2, ack2;
    logic [11:0] at1, ab1, at2, ab2;
    logic [2:0]  rt1, rb1, rt2, rb2;
    logic [15:0] d1t, d1b, p2t, p2b, d2t, d2b;
    logic [15:0] mem [4096];

    framebuffer_fetch #(.RAM_LATENCY(1)) dut (
        .clk_in(clk), .reset(reset), .column_address(col), .row_address(row),
        .brightness_mask(mask), .pixel_load_en(load), .swap_req(swap_req),
        .ram_rd_en(rd1), .ram_addr_top(at1), .ram_addr_bot(ab1),
        .ram_data_top(d1t), .ram_data_bot(d1b), .rgb_top(rt1), .rgb_bot(rb1),
        .rgb_valid(v1), .front_buffer(fb1), .swap_ack(ack1));

    framebuffer_fetch #(.RAM_LATENCY(2)) dut2 (
        .clk_in(clk), .reset(reset), .column_address(col), .row_address(row),
        .brightness_mask(mask), .pixel_load_en(load), .swap_req(swap_req),
        .ram_rd_en(rd2), .ram_addr_top(at2), .ram_addr_bot(ab2),
        .ram_data_top(d2t), .ram_data_bot(d2b), .rgb_top(rt2), .rgb_bot(rb2),
        .rgb_valid(v2), .front_buffer(fb2), .swap_ack(ack2));

    // Synchronous RAMs with one and two cycles of read latency
    always @(posedge clk) begin
        d1t <= mem[at1];
        d1b <= mem[ab1];
        p2t <= mem[at2];
        p2b <= mem[ab2];
        d2t <= p2t;
        d2b <= p2b;
    end

    int checks = 0, errors = 0;
    int k = 0, last_rst = 0;
    bit ld_h [64];
    int a_h [64];
    int mk_h [64];
    int m_fb, m_pend, m_bnd, m_prev, m_ack, m_rd, m_at, m_ab;
    logic [2:0] e_top [2];
    logic [2:0] e_bot [2];
    bit e_v [2];
    int ack_cnt = 0, run = 0, last_run = 0, first_v1 = -1, first_v2 = -1;

    function automatic logic [2:0] pix(input int w, input int m);
        int r, g, b;
        r = (w >> 11) & 31;
        g = (w >> 5) & 63;
        b = w & 31;
        r = r * 2 + r / 16;
        b = b * 2 + b / 16;
        if (GX != 0) begin
            r = (r * r + 31) / 63;
            g = (g * g + 31) / 63;
            b = (b * b + 31) / 63;
        end
        return {(r & m) != 0, (g & m) != 0, (b & m) != 0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int sw, lat, j;
        if (reset) begin
            m_fb = 0; m_pend = 0; m_bnd = 0; m_prev = 0; m_ack = 0;
            m_rd = 0; m_at = 0; m_ab = 0;
            last_rst = k;
            ld_h[k % 64] = 1'b0;
            for (int d = 0; d < 2; d++) begin
                e_v[d] = 1'b0; e_top[d] = '0; e_bot[d] = '0;
            end
        end else begin
            ld_h[k % 64] = load;
            m_rd = int'(load);
            if (load) begin
                m_at = m_fb * 2048 + int'(row) * 64 + int'(col);
                m_ab = m_at + 1024;
                a_h[k % 64]  = m_at;
                mk_h[k % 64] = int'(mask);
            end
            sw = (m_bnd != 0 && m_pend != 0 && !load) ? 1 : 0;
            m_ack = sw;
            m_pend = (sw != 0) ? int'(swap_req) : ((m_pend != 0 || swap_req) ? 1 : 0);
            if (sw != 0) m_fb = 1 - m_fb;
            if (row == 0 && m_prev == 15) m_bnd = 1;
            else if (!load) m_bnd = 0;
            m_prev = int'(row);
            for (int d = 0; d < 2; d++) begin
                lat = 3 + d + GX;
                j = k - lat;
                e_v[d] = (j >= 0 && j > last_rst) ? ld_h[j % 64] : 1'b0;
                if (e_v[d]) begin
                    e_top[d] = pix(int'(mem[a_h[j % 64]]), mk_h[j % 64]);
                    e_bot[d] = pix(int'(mem[a_h[j % 64] + 1024]), mk_h[j % 64]);
                end
            end
        end
    endtask

    task automatic check_all();
        chk("ram_rd_en", 32'(rd1), 32'(m_rd));
        chk("ram_addr_top", 32'(at1), 32'(m_at));
        chk("ram_addr_bot", 32'(ab1), 32'(m_ab));
        chk("front_buffer", 32'(fb1), 32'(m_fb));
        chk("swap_ack", 32'(ack1), 32'(m_ack));
        chk("rgb_valid_l1", 32'(v1), 32'(e_v[0]));
        chk("rgb_top_l1", 32'(rt1), 32'(e_top[0]));
        chk("rgb_bot_l1", 32'(rb1), 32'(e_bot[0]));
        chk("rgb_valid_l2", 32'(v2), 32'(e_v[1]));
        chk("rgb_top_l2", 32'(rt2), 32'(e_top[1]));
        chk("rgb_bot_l2", 32'(rb2), 32'(e_bot[1]));
        if (ack1) ack_cnt++;
        if (v1 && first_v1 < 0) first_v1 = k;
        if (v2 && first_v2 < 0) first_v2 = k;
        if (v1) run++;
        else if (run > 0) begin last_run = run; run = 0; end
    endtask

    task automatic tick();
        @(posedge clk);
        k++;
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        load = 1'b0;
        swap_req = 1'b0;
        repeat (n) tick();
    endtask

    task automatic fill(input bit rnd, input logic [15:0] top, input logic [15:0] bot);
        for (int a = 0; a < 4096; a++)
            mem[a] = rnd ? 16'($urandom) : (((a & 1024) != 0) ? bot : top);
    endtask

    // Two blanking cycles at the new row, then 64 column loads
    task automatic line(input int r, input int m, input int bubble_pct, input int swap_col);
        load = 1'b0; swap_req = 1'b0;
        row = 4'(r); mask = 6'(m);
        repeat (2) tick();
        for (int c = 0; c < 64; c++) begin
            col = 6'(c);
            load = ($urandom_range(0, 99) >= bubble_pct);
            swap_req = (c == swap_col);
            tick();
        end
        load = 1'b0; swap_req = 1'b0;
    endtask

    function automatic int rand_mask();
        int s;
        s = $urandom_range(0, 6);
        return (s == 6) ? 0 : (1 << s);
    endfunction

    initial begin
        int first_load_k, acks_before;
        fill(1'b0, 16'h0000, 16'h0000);
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Red top / blue bottom on the MSB plane, no bubbles
        fill(1'b0, 16'hF800, 16'h001F);
        first_v1 = -1; first_v2 = -1;
        first_load_k = k + 3;
        line(0, 6'b100000, 0, -1);
        idle(8);
        chk("latency_l1", 32'(first_v1 - first_load_k), 32'(3 + GX));
        chk("latency_l2", 32'(first_v2 - first_load_k), 32'(4 + GX));
        chk("valid_run", 32'(last_run), 32'd64);
        chk("red_top", 32'(rt1), 32'(3'b100));
        chk("blue_bot", 32'(rb1), 32'(3'b001));

        // Full green across all six planes, then G6=32 on each plane
        fill(1'b0, 16'h07E0, 16'h001F);
        for (int p = 5; p >= 0; p--) line(0, 1 << p, 0, -1);
        idle(8);
        chk("green_lsb", 32'(rt1), 32'(3'b010));
        fill(1'b0, 16'h0400, 16'h0000);
        for (int p = 5; p >= 0; p--) line(0, 1 << p, 0, -1);
        idle(8);

        // Swap requested at row 5 and again at row 9: exactly one toggle after the wrap
        fill(1'b1, 16'h0000, 16'h0000);
        acks_before = ack_cnt;
        for (int r = 0; r < 16; r++)
            line(r, rand_mask(), 0, (r == 5) ? 10 : ((r == 9) ? 3 : -1));
        chk("fb_before_wrap", 32'(fb1), 32'd0);
        line(0, rand_mask(), 0, -1);
        line(1, rand_mask(), 0, -1);
        chk("swap_ack_count", 32'(ack_cnt - acks_before), 32'd1);
        chk("fb_after_wrap", 32'(fb1), 32'd1);
        chk("addr_top_msb", 32'(at1[11]), 32'd1);

        // Random frames with load bubbles and sporadic swap requests
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < 16; r++)
                line(r, rand_mask(), 10,
                     ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 63)) : -1);
        line(0, rand_mask(), 10, -1);

        // Reset in the middle of a load burst with a swap pending
        load = 1'b0; row = 4'd15; mask = 6'b100000;
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        for (int c = 0; c < 10; c++) begin col = 6'(c); load = 1'b1; tick(); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset_valid", 32'(v1), 32'd0);
        chk("reset_rd_en", 32'(rd1), 32'd0);
        chk("reset_fb", 32'(fb1), 32'd0);
        for (int c = 11; c < 30; c++) begin col = 6'(c); tick(); end
        acks_before = ack_cnt;
        line(0, rand_mask(), 0, -1);
        line(1, rand_mask(), 0, -1);
        idle(10);
        chk("pending_lost", 32'(ack_cnt - acks_before), 32'd0);
        chk("fb_after_reset", 32'(fb1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
